// File: rtl/pcr_reagent_dispenser.sv
// rtl/pcr_reagent_dispenser.sv - reagent inlet sequencer: per-inlet valve/pump stepping, then outlet flush
module pcr_reagent_dispenser #(
    parameter int N_CH       = 6,
    parameter int VOL_W      = 8,
    parameter int STEP_DIV   = 4,
    parameter int SETTLE_CYC = 3,
    parameter int FLUSH_CYC  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    vol_wr_en_i,
    input  logic [$clog2(N_CH)-1:0] vol_wr_idx_i,
    input  logic [VOL_W-1:0]        vol_wr_data_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    output logic [N_CH-1:0]         valve_open_o,
    output logic [N_CH-1:0]         pump_step_o,
    output logic                    out_valve_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o
);
    localparam int IDX_W   = $clog2(N_CH);
    localparam int CH_W    = $clog2(N_CH + 1);
    localparam int MAX_A   = (STEP_DIV > SETTLE_CYC) ? STEP_DIV : SETTLE_CYC;
    localparam int CNT_MAX = (MAX_A > FLUSH_CYC) ? MAX_A : FLUSH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SKIPCHK, S_OPEN, S_PUMP, S_CLOSE, S_FLUSH, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VOL_W-1:0]  vrem_q, vrem_d;
    logic              aborted_q, aborted_d;
    logic              snap;
    logic [VOL_W-1:0]  vol_q  [N_CH];
    logic [VOL_W-1:0]  work_q [N_CH];
    logic [IDX_W-1:0]  ch_idx;
    logic [VOL_W-1:0]  cur_vol;
    logic [N_CH-1:0]   ch_oh;
    logic              in_range;

    // ch_q reaches N_CH after the last inlet closes, so guard the working-set read
    assign in_range = (ch_q < CH_W'(N_CH));
    assign ch_idx   = ch_q[IDX_W-1:0];
    assign cur_vol  = in_range ? work_q[ch_idx] : '0;
    assign ch_oh    = N_CH'(1) << ch_q;

    assign valve_open_o = (state_q == S_OPEN || state_q == S_PUMP) ? ch_oh : '0;
    assign pump_step_o  = (state_q == S_PUMP && cnt_q == '0) ? ch_oh : '0;
    assign out_valve_o  = (state_q == S_FLUSH);
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done_o       = (state_q == S_FIN);
    assign aborted_o    = aborted_q;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        vrem_d    = vrem_q;
        aborted_d = 1'b0;
        snap      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_SKIPCHK;
                    ch_d    = '0;
                    cnt_d   = '0;
                    snap    = 1'b1;
                end
            end
            S_SKIPCHK: begin
                cnt_d = '0;
                if (!in_range) begin
                    state_d = S_FLUSH;
                end else if (cur_vol != '0) begin
                    state_d = S_OPEN;
                end else if (ch_q == CH_W'(N_CH - 1)) begin
                    state_d = S_FLUSH;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            S_OPEN: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_PUMP;
                    cnt_d   = '0;
                    vrem_d  = cur_vol;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PUMP: begin
                // vrem counts pulses still owed, including the window in progress
                if (cnt_q == CNT_W'(STEP_DIV - 1)) begin
                    cnt_d = '0;
                    if (vrem_q == VOL_W'(1)) begin
                        state_d = S_CLOSE;
                    end else begin
                        vrem_d = vrem_q - VOL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLOSE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_SKIPCHK;
                    cnt_d   = '0;
                    ch_d    = ch_q + CH_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_i && state_q != S_IDLE && state_q != S_FIN) begin
            state_d   = S_IDLE;
            ch_d      = '0;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            vrem_q    <= '0;
            aborted_q <= 1'b0;
            vol_q     <= '{default: '0};
            work_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            vrem_q    <= vrem_d;
            aborted_q <= aborted_d;
            if (vol_wr_en_i && !busy_o && ({1'b0, vol_wr_idx_i} < (IDX_W + 1)'(N_CH))) begin
                vol_q[vol_wr_idx_i] <= vol_wr_data_i;
            end
            if (snap) begin
                work_q <= vol_q;
            end
        end
    end
endmodule

// File: tb/tb_pcr_reagent_dispenser.sv
// tb/tb_pcr_reagent_dispenser.sv - randomized self-checking bench with per-cycle trace model
module tb_pcr_reagent_dispenser;
    localparam int N_CH   = 6;
    localparam int DIV    = 4;
    localparam int SETTLE = 3;
    localparam int FLUSH  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vol_wr_en = 1'b0;
    logic [2:0] vol_wr_idx = '0;
    logic [7:0] vol_wr_data = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] valve_open, pump_step;
    logic       out_valve, busy, done, aborted;

    int n_checks = 0;
    int n_err    = 0;
    int mvol [N_CH];
    logic [15:0] exp_q [$];

    pcr_reagent_dispenser #(
        .N_CH(N_CH), .VOL_W(8), .STEP_DIV(DIV), .SETTLE_CYC(SETTLE), .FLUSH_CYC(FLUSH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .vol_wr_en_i(vol_wr_en), .vol_wr_idx_i(vol_wr_idx), .vol_wr_data_i(vol_wr_data),
        .start_i(start), .abort_i(abort),
        .valve_open_o(valve_open), .pump_step_o(pump_step), .out_valve_o(out_valve),
        .busy_o(busy), .done_o(done), .aborted_o(aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pack();
        return {valve_open, pump_step, out_valve, busy, done, aborted};
    endfunction

    function automatic logic [15:0] ev(input logic [5:0] v, input logic [5:0] p,
                                       input logic o, input logic b, input logic d);
        return {v, p, o, b, d, 1'b0};
    endfunction

    // Expected output per clock, starting with the clock after start is sampled
    task automatic build_model();
        exp_q.delete();
        for (int ch = 0; ch < N_CH; ch++) begin
            logic [5:0] oh;
            oh = 6'(1 << ch);
            exp_q.push_back(ev(0, 0, 0, 1, 0));
            if (mvol[ch] != 0) begin
                for (int k = 0; k < SETTLE; k++) exp_q.push_back(ev(oh, 0, 0, 1, 0));
                for (int k = 0; k < mvol[ch] * DIV; k++)
                    exp_q.push_back(ev(oh, (k % DIV == 0) ? oh : 6'd0, 0, 1, 0));
                for (int k = 0; k < SETTLE; k++) exp_q.push_back(ev(0, 0, 0, 1, 0));
            end
        end
        if (mvol[N_CH-1] != 0) exp_q.push_back(ev(0, 0, 0, 1, 0));
        for (int k = 0; k < FLUSH; k++) exp_q.push_back(ev(0, 0, 1, 1, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 1));
        exp_q.push_back(16'h0000);
    endtask

    function automatic int find_nth(input logic [15:0] mask, input int nth);
        int seen = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if ((exp_q[i] & mask) != 0) begin
                seen++;
                if (seen == nth) return i;
            end
        end
        return -1;
    endfunction

    task automatic write_vol(input int idx, input int data);
        vol_wr_en = 1'b1; vol_wr_idx = 3'(idx); vol_wr_data = 8'(data);
        tick();
        vol_wr_en = 1'b0;
        if (idx < N_CH) mvol[idx] = data;
    endtask

    // kill_kind: 0 none, 1 abort, 2 reset, applied in the clock after trace index kill_at
    task automatic run(input string name, input int kill_at, input int kill_kind, input int inj_at);
        int n, fin_idx, pulses, exp_pulses;
        logic inv;
        n = exp_q.size();
        fin_idx = n - 2;
        pulses = 0;
        exp_pulses = 0;
        for (int c = 0; c < N_CH; c++) exp_pulses += mvol[c];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s cyc%0d", name, i), pack(), exp_q[i]);
            inv = ($countones(valve_open) <= 1) && !(out_valve && valve_open != 0)
                  && ((pump_step & ~valve_open) == 0);
            check($sformatf("%s inv%0d", name, i), inv, 1'b1);
            pulses += $countones(pump_step);
            if (i == inj_at) begin
                vol_wr_en = 1'b1; vol_wr_idx = 3'd0; vol_wr_data = 8'd9; start = 1'b1;
            end
            if (i == kill_at && kill_kind == 1) abort = 1'b1;
            if (i == kill_at && kill_kind == 2) rst = 1'b1;
            tick();
            vol_wr_en = 1'b0; start = 1'b0; abort = 1'b0; rst = 1'b0;
            if (i == kill_at && kill_kind != 0 && i < fin_idx) begin
                check($sformatf("%s kill", name), pack(), (kill_kind == 1) ? 16'h0001 : 16'h0000);
                if (kill_kind == 2) foreach (mvol[c]) mvol[c] = 0;
                tick();
                check($sformatf("%s after_kill", name), pack(), 16'h0000);
                return;
            end
        end
        check($sformatf("%s pulses", name), pulses, exp_pulses);
    endtask

    task automatic load(input int v0, v1, v2, v3, v4, v5);
        write_vol(0, v0); write_vol(1, v1); write_vol(2, v2);
        write_vol(3, v3); write_vol(4, v4); write_vol(5, v5);
    endtask

    initial begin
        foreach (mvol[c]) mvol[c] = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset", pack(), 16'h0000);

        load(2, 2, 1, 1, 1, 1);
        build_model(); run("mix", -1, 0, -1);

        load(0, 3, 0, 0, 0, 0);
        build_model(); run("ch1only", -1, 0, -1);

        load(0, 0, 0, 0, 0, 0);
        build_model(); run("allzero", -1, 0, -1);

        load(0, 0, 5, 0, 0, 0);
        build_model(); run("abort3rd", find_nth(16'h03F0, 3), 1, -1);

        load(4, 1, 0, 0, 0, 2);
        build_model(); run("busywr", -1, 0, 5);
        build_model(); run("busywr2", -1, 0, -1);

        write_vol(6, 77); write_vol(7, 88);
        load(1, 0, 0, 0, 0, 0);
        build_model(); run("abortfin", exp_q.size() - 2, 1, -1);

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort", pack(), 16'h0000);
        tick();
        check("start_abort2", pack(), 16'h0000);

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N_CH; c++)
                write_vol(c, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4));
            build_model();
            if ($urandom_range(0, 1) == 1)
                run($sformatf("rnd%0d", r), $urandom_range(0, exp_q.size() - 2), 1, -1);
            else
                run($sformatf("rnd%0d", r), -1, 0, -1);
        end

        load(0, 0, 0, 0, 0, 255);
        build_model(); run("max255", -1, 0, -1);
        build_model(); run("rstflush", find_nth(16'h0008, 1) + 5, 2, -1);
        build_model(); run("postrst", -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
